// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-rate divider, h/v counters and
// registered sync/blanking decodes that always describe the displayed pixel.
module vga_sync_gen #(
   parameter int CLK_DIV   = 4,
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       reset,
   output logic       p_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_SYNC_BEG = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0] V_SYNC_BEG = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_SYNC);
   localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
   localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);

   logic [3:0] div;
   logic [9:0] h_count;
   logic [9:0] v_count;
   logic [9:0] h_next;
   logic [9:0] v_next;
   logic       h_wrap;
   logic       hsync_next;
   logic       vsync_next;
   logic       video_next;

   // Decodes are taken from the next-state counts so the registered syncs
   // and video_on land on the same edge as the counts they describe.
   always_comb begin
      h_wrap     = (h_count == H_LAST);
      h_next     = h_wrap ? '0 : h_count + 10'd1;
      v_next     = v_count;
      if (h_wrap)
         v_next = (v_count == V_LAST) ? '0 : v_count + 10'd1;
      hsync_next = !((h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END));
      vsync_next = !((v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END));
      video_next = (h_next < H_VIS) && (v_next < V_VIS);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div         <= '0;
         p_tick      <= 1'b0;
         h_count     <= '0;
         v_count     <= '0;
         video_on    <= 1'b0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         p_tick      <= (div == DIV_LAST);
         div         <= (div == DIV_LAST) ? '0 : div + 4'd1;
         frame_start <= 1'b0;
         if (p_tick) begin
            h_count     <= h_next;
            v_count     <= v_next;
            hsync       <= hsync_next;
            vsync       <= vsync_next;
            video_on    <= video_next;
            frame_start <= (h_next == '0) && (v_next == '0);
         end
      end
   end

   assign pixel_x = h_count;
   assign pixel_y = v_count;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a shrunk-timing CLK_DIV=4 instance and a full
// 640x480 CLK_DIV=1 instance, both scored every clock against a clock-count model.
module tb_vga_sync_gen;

   localparam int D_A = 4;
   localparam int HD = 16, HF = 4, HS = 6, HB = 4;
   localparam int VD = 10, VF = 2, VS = 2, VB = 3;
   localparam int HT = HD + HF + HS + HB;
   localparam int VT = VD + VF + VS + VB;

   typedef struct packed {
      logic       pt;
      logic [9:0] x;
      logic [9:0] y;
      logic       von;
      logic       hs;
      logic       vs;
      logic       fs;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pt_a, von_a, hs_a, vs_a, fs_a;
   logic [9:0] x_a, y_a;
   logic       pt_b, von_b, hs_b, vs_b, fs_b;
   logic [9:0] x_b, y_b;

   int errors = 0;
   int checks = 0;
   int k = 0;
   obs_t q_a[$];
   obs_t q_b[$];

   int fcnt_a = 0, fk1 = 0, fk2 = 0;
   int von_cnt = 0, hs_cnt = 0, vs_cnt = 0, pt_cnt = 0;
   int wraps_b = 0, w1 = 0, w2 = 0, hs1_cnt = 0, hs1_x = -1;
   logic [9:0] prev_x_b = '0;

   vga_sync_gen #(
      .CLK_DIV(D_A), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut_a (
      .clk(clk), .reset(reset), .p_tick(pt_a), .pixel_x(x_a), .pixel_y(y_a),
      .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
   );

   vga_sync_gen #(
      .CLK_DIV(1)
   ) dut_b (
      .clk(clk), .reset(reset), .p_tick(pt_b), .pixel_x(x_b), .pixel_y(y_b),
      .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .frame_start(fs_b)
   );

   always #5 clk = ~clk;

   // k = clock edges since reset release
   always @(posedge clk or negedge reset) begin
      if (!reset) k <= 0;
      else        k <= k + 1;
   end

   // After edge kk: ticks fire on edges d, 2d, ...; the counters advance on
   // the edge following each tick, so (kk-1)/d pixels have been stepped.
   function automatic obs_t model(input int kk, input int d,
                                  input int hd, input int hf, input int hsw, input int hb,
                                  input int vd, input int vf, input int vsw, input int vb);
      obs_t e;
      int ht, vt, a, p, x, y;
      bit adv;
      ht = hd + hf + hsw + hb;
      vt = vd + vf + vsw + vb;
      if (kk == 0) begin
         e = '{pt: 1'b0, x: 10'd0, y: 10'd0, von: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
      end else begin
         a   = (kk - 1) / d;
         p   = a % (ht * vt);
         x   = p % ht;
         y   = p / ht;
         adv = (kk - 1 >= d) && ((kk - 1) % d == 0);
         e.pt  = (kk >= d) && (kk % d == 0);
         e.x   = 10'(x);
         e.y   = 10'(y);
         e.von = (a > 0) && (x < hd) && (y < vd);
         e.hs  = !((x >= hd + hf) && (x < hd + hf + hsw));
         e.vs  = !((y >= vd + vf) && (y < vd + vf + vsw));
         e.fs  = adv && (p == 0);
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d (k=%0d)", tag, obs, exp, k);
      end
   endtask

   task automatic cmp(input string pre, input obs_t o, input obs_t e);
      chk({pre, ".p_tick"},      32'(o.pt),  32'(e.pt));
      chk({pre, ".pixel_x"},     32'(o.x),   32'(e.x));
      chk({pre, ".pixel_y"},     32'(o.y),   32'(e.y));
      chk({pre, ".video_on"},    32'(o.von), 32'(e.von));
      chk({pre, ".hsync"},       32'(o.hs),  32'(e.hs));
      chk({pre, ".vsync"},       32'(o.vs),  32'(e.vs));
      chk({pre, ".frame_start"}, 32'(o.fs),  32'(e.fs));
   endtask

   function automatic obs_t model_a(input int kk);
      return model(kk, D_A, HD, HF, HS, HB, VD, VF, VS, VB);
   endfunction

   function automatic obs_t model_b(input int kk);
      return model(kk, 1, 640, 16, 96, 48, 480, 10, 2, 33);
   endfunction

   // Scoreboard plus frame/line statistics, sampled mid-cycle.
   always @(negedge clk) begin
      obs_t ea, eb;
      q_a.push_back(model_a(k));
      q_b.push_back(model_b(k));
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      cmp("a", '{pt_a, x_a, y_a, von_a, hs_a, vs_a, fs_a}, ea);
      cmp("b", '{pt_b, x_b, y_b, von_b, hs_b, vs_b, fs_b}, eb);

      if (fs_a) begin
         fcnt_a++;
         if (fcnt_a == 1) fk1 = k;
         if (fcnt_a == 2) fk2 = k;
      end
      if (pt_a && fcnt_a == 1) begin
         pt_cnt++;
         if (von_a) von_cnt++;
         if (!hs_a) hs_cnt++;
         if (!vs_a) vs_cnt++;
      end

      if (x_b == 10'd0 && prev_x_b == 10'd799) begin
         wraps_b++;
         if (wraps_b == 1) w1 = k;
         if (wraps_b == 2) w2 = k;
      end
      prev_x_b = x_b;
      if (!hs_b && wraps_b == 0) begin
         if (hs1_cnt == 0) hs1_x = int'(x_b);
         hs1_cnt++;
      end
   end

   initial begin
      int n;
      #2 reset = 1'b0;
      #1;
      cmp("rst0.a", '{pt_a, x_a, y_a, von_a, hs_a, vs_a, fs_a}, model_a(0));
      cmp("rst0.b", '{pt_b, x_b, y_b, von_b, hs_b, vs_b, fs_b}, model_b(0));
      #30 reset = 1'b1;

      n = 0;
      while (!pt_a && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("first_ptick_clk", 32'(k), 32'd4);

      n = 0;
      while (fcnt_a < 2 && n < 10000) begin
         @(negedge clk);
         n++;
      end
      chk("frame_wait_done",  32'(fcnt_a >= 2), 32'd1);
      chk("frame_period_clk", 32'(fk2 - fk1),   32'(HT * VT * D_A));
      chk("frame_ptick_cnt",  32'(pt_cnt),      32'(HT * VT));
      chk("frame_video_cnt",  32'(von_cnt),     32'(HD * VD));
      chk("frame_hsync_cnt",  32'(hs_cnt),      32'(HS * VT));
      chk("frame_vsync_cnt",  32'(vs_cnt),      32'(VS * HT));
      chk("div1_line_clks",   32'(w2 - w1),     32'd800);
      chk("div1_hsync_start", 32'(hs1_x),       32'd656);
      chk("div1_hsync_width", 32'(hs1_cnt),     32'd96);

      // Mid-frame reset, deliberately off the clock edge.
      repeat (137) @(negedge clk);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      cmp("rst1.a", '{pt_a, x_a, y_a, von_a, hs_a, vs_a, fs_a}, model_a(0));
      cmp("rst1.b", '{pt_b, x_b, y_b, von_b, hs_b, vs_b, fs_b}, model_b(0));
      #29 reset = 1'b1;

      n = 0;
      while (!pt_a && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("restart_ptick_clk", 32'(k), 32'd4);

      repeat (300) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
